// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// Optional first-failure capture is enabled with FIRST_FAIL_CAPTURE_EN.
package adder_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam int SETTLE_W = 4;

    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int sum_w(input int n_in, input int n_out);
        return n_in + n_out;
    endfunction

    function automatic int diff_w(input int n_out);
        return n_out + 1;
    endfunction

endpackage

// File: rtl/adder_eval_if.sv
// Stimulus/response bus between the monitor and the adder under evaluation.
// Optional first-failure capture is enabled with FIRST_FAIL_CAPTURE_EN.
interface adder_eval_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
);

    logic [N_IN-1:0]  pi_out;
    logic [N_OUT-1:0] po_in;

    modport master (
        output pi_out,
        input  po_in
    );

    modport slave (
        input  pi_out,
        output po_in
    );

endinterface

// File: rtl/adder_exact_ref.sv
// Exact a+b reference; a is the low half of pi, b the high half.
// Optional first-failure capture is enabled with FIRST_FAIL_CAPTURE_EN.
module adder_exact_ref #(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] pi,
    output logic [N_IN/2:0] sum
);

    localparam int H = N_IN / 2;

    assign sum = {1'b0, pi[H-1:0]} + {1'b0, pi[N_IN-1:H]};

endmodule

// File: rtl/adder_error_monitor.sv
// Sweeps all input vectors into an adder and accumulates error metrics.
// Optional first-failure capture is enabled with FIRST_FAIL_CAPTURE_EN.
module adder_error_monitor
    import adder_eval_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    adder_eval_if.master bus,
    output logic busy,
    output logic done,
    output logic [cnt_w(N_IN)-1:0] err_count,
    output logic [N_OUT-1:0] max_abs_err,
    output logic [sum_w(N_IN, N_OUT)-1:0] sum_abs_err
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
`endif
);

    localparam int SW = sum_w(N_IN, N_OUT);
    localparam int DW = diff_w(N_OUT);

    state_t state_q, state_d;

    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [N_IN-1:0] pi_q;
    logic clear, sample;

    logic [N_IN/2:0] exact;
    logic [DW-1:0] diff;
    logic [N_OUT-1:0] abs_err;

    adder_exact_ref #(
        .N_IN(N_IN)
    ) u_ref (
        .pi (pi_q),
        .sum(exact)
    );

    // Two's-complement difference in one extra bit, then magnitude.
    assign diff = DW'(exact) - DW'(bus.po_in);
    assign abs_err = diff[DW-1] ? N_OUT'(-diff) : N_OUT'(diff);

    assign bus.pi_out = pi_q;
    assign busy = (state_q == WAIT) || (state_q == SAMPLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        clear    = 1'b0;
        sample   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = WAIT;
                    settle_d = '0;
                    clear    = 1'b1;
                end
            end
            WAIT: begin
                if (settle_q == SETTLE_W'(SETTLE - 1)) begin
                    state_d  = SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                sample  = 1'b1;
                state_d = (pi_q == '1) ? DONE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q        <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (clear) begin
            pi_q        <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (sample) begin
            if (abs_err != '0) begin
                err_count <= err_count + 1'b1;
            end
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end
            sum_abs_err <= sum_abs_err + SW'(abs_err);
            // The last vector stays on the bus while results are held.
            if (pi_q != '1) begin
                pi_q <= pi_q + 1'b1;
            end
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (clear) begin
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (sample && abs_err != '0 && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= pi_q;
        end
    end
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomized self-checking bench for adder_error_monitor.
// Optional first-failure capture is checked when FIRST_FAIL_CAPTURE_EN is set.
module tb_adder_error_monitor;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int SETTLE = 1;
    localparam int PER    = SETTLE + 1;
    localparam int NV     = 1 << N_IN;
    localparam int DONE_J = NV * PER;
    localparam int H      = N_IN / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    adder_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    logic busy, done;
    logic [N_IN:0] err_count;
    logic [N_OUT-1:0] max_abs_err;
    logic [N_IN+N_OUT-1:0] sum_abs_err;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic first_fail_valid;
    logic [N_IN-1:0] first_fail_vec;
`endif

    adder_error_monitor #(
        .N_IN(N_IN),
        .N_OUT(N_OUT),
        .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .err_count(err_count),
        .max_abs_err(max_abs_err),
        .sum_abs_err(sum_abs_err)
`ifdef FIRST_FAIL_CAPTURE_EN
        ,
        .first_fail_valid(first_fail_valid),
        .first_fail_vec(first_fail_vec)
`endif
    );

    // Adder under evaluation: 0 exact, 1 stuck-at-zero, 2 OR, 3 random table.
    int mode = 0;
    int sw_mode = 0;
    logic [N_OUT-1:0] lut [NV];
    logic [N_OUT-1:0] lut_sw [NV];

    always_comb begin
        case (mode)
            0: bus.po_in = N_OUT'(bus.pi_out[H-1:0]) + N_OUT'(bus.pi_out[N_IN-1:H]);
            1: bus.po_in = '0;
            2: bus.po_in = N_OUT'(bus.pi_out[H-1:0] | bus.pi_out[N_IN-1:H]);
            default: bus.po_in = lut[bus.pi_out];
        endcase
    end

    // Reference timeline: trk = a sweep was accepted, j = edges since then.
    bit trk;
    int j;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk <= 1'b0;
            j   <= 0;
        end else if (start && (!trk || j >= DONE_J)) begin
            trk     <= 1'b1;
            j       <= 0;
            sw_mode <= mode;
            lut_sw  <= lut;
        end else if (trk && j < DONE_J) begin
            j <= j + 1;
        end
    end

    function automatic void model(input int m, input int nv,
                                  output int ec, output int mx,
                                  output int sm, output int fv);
        int a, b, ex, p, d;
        ec = 0; mx = 0; sm = 0; fv = -1;
        for (int v = 0; v < nv; v++) begin
            a  = v % (1 << H);
            b  = v >> H;
            ex = a + b;
            case (m)
                0: p = ex;
                1: p = 0;
                2: p = a | b;
                default: p = int'(lut_sw[v]);
            endcase
            d = ex - p;
            if (d < 0) d = -d;
            if (d != 0) begin
                ec++;
                if (fv < 0) fv = v;
            end
            if (d > mx) mx = d;
            sm += d;
        end
    endfunction

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int nv, ec, mx, sm, fv;
        if (rst_n) begin
            nv = !trk ? 0 : (j >= DONE_J ? NV : j / PER);
            model(sw_mode, nv, ec, mx, sm, fv);
            chk("busy", 64'(busy), 64'(trk && j < DONE_J));
            chk("done", 64'(done), 64'(trk && j >= DONE_J));
            chk("pi_out", 64'(bus.pi_out),
                64'(!trk ? 0 : (j >= DONE_J ? NV - 1 : j / PER)));
            chk("err_count", 64'(err_count), 64'(ec));
            chk("max_abs_err", 64'(max_abs_err), 64'(mx));
            chk("sum_abs_err", 64'(sum_abs_err), 64'(sm));
`ifdef FIRST_FAIL_CAPTURE_EN
            chk("first_fail_valid", 64'(first_fail_valid), 64'(fv >= 0));
            chk("first_fail_vec", 64'(first_fail_vec), 64'(fv >= 0 ? fv : 0));
`endif
        end
    end

    task automatic pin(input int m);
        chk("pin_done", 64'(done), 64'd1);
        case (m)
            0: begin
                chk("pin_exact_err", 64'(err_count), 64'd0);
                chk("pin_exact_max", 64'(max_abs_err), 64'd0);
                chk("pin_exact_sum", 64'(sum_abs_err), 64'd0);
            end
            1: begin
                chk("pin_zero_err", 64'(err_count), 64'd15);
                chk("pin_zero_max", 64'(max_abs_err), 64'd6);
                chk("pin_zero_sum", 64'(sum_abs_err), 64'd48);
            end
            2: begin
                chk("pin_or_err", 64'(err_count), 64'd7);
                chk("pin_or_max", 64'(max_abs_err), 64'd3);
                chk("pin_or_sum", 64'(sum_abs_err), 64'd12);
`ifdef FIRST_FAIL_CAPTURE_EN
                chk("pin_or_ffv", 64'(first_fail_valid), 64'd1);
                chk("pin_or_ffvec", 64'(first_fail_vec), 64'd5);
`endif
            end
            default: ;
        endcase
    endtask

    // pulse: 0 none, 1 at cycles 5 and 20, 2 random; hold keeps start high into DONE.
    task automatic sweep(input int m, input int pulse, input bit hold);
        @(negedge clk);
        mode = m;
        if (m == 3) begin
            foreach (lut[i]) lut[i] = N_OUT'($urandom);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= DONE_J; i++) begin
            @(negedge clk);
            case (pulse)
                1: start = (i == 5 || i == 20);
                2: start = (i < DONE_J) ? 1'($urandom % 2) : 1'b0;
                default: start = 1'b0;
            endcase
            if (hold && i >= DONE_J - 1) start = 1'b1;
        end
        pin(m);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_pi"}, 64'(bus.pi_out), 64'd0);
        chk({nm, "_err"}, 64'(err_count), 64'd0);
        chk({nm, "_max"}, 64'(max_abs_err), 64'd0);
        chk({nm, "_sum"}, 64'(sum_abs_err), 64'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk({nm, "_ffv"}, 64'(first_fail_valid), 64'd0);
`endif
    endtask

    initial begin
        int ec, mx, sm, fv;
        foreach (lut[i]) lut[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        #2 rst_n = 1'b1;

        model(2, NV, ec, mx, sm, fv);
        chk("model_or_err", 64'(ec), 64'd7);
        chk("model_or_max", 64'(mx), 64'd3);
        chk("model_or_sum", 64'(sm), 64'd12);
        chk("model_or_first", 64'(fv), 64'd5);
        model(1, NV, ec, mx, sm, fv);
        chk("model_zero_sum", 64'(sm), 64'd48);

        sweep(0, 0, 1'b0);
        sweep(1, 0, 1'b0);
        sweep(2, 0, 1'b0);

        // Abort a sweep mid-way with an asynchronous reset.
        @(negedge clk);
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sweep(2, 0, 1'b0);

        sweep(0, 1, 1'b0);
        sweep(0, 2, 1'b0);

        // start held across DONE restarts immediately.
        sweep(2, 0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", 64'(busy), 64'd1);
        chk("hold_restart_err", 64'(err_count), 64'd0);
        repeat (DONE_J) @(negedge clk);
        pin(2);

        for (int k = 0; k < 4; k++) sweep(3, 2, 1'b0);
        sweep(1, 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
